// File: rtl/branch_resolve_unit_pkg.sv
// Shared types and constants for the EX-stage branch resolve unit.
//
// Contents:
//   BR_WD           width of the {e, target} prediction/redirect buses
//   STALL_W         width of the pipeline stall vector
//   STALL_EX        index of the EX hold bit inside the stall vector
//   STOP / NO_STOP  values of a stall bit (hold / advance)
//   brs_state_e     redirect FSM state (IDLE = 1'b0, HOLD = 1'b1)
//   br_bus_t        packed view of an {e, target} bus
//   resolve_redirect  compares a prediction against the real outcome
package branch_resolve_unit_pkg;

  localparam int BR_WD    = 33;
  localparam int STALL_W  = 6;
  localparam int STALL_EX = 3;

  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } brs_state_e;

  typedef struct packed {
    logic        e;
    logic [31:0] target;
  } br_bus_t;

  // Returns {1, redirect address} when the prediction was wrong, else all
  // zeros. A predicted-taken non-branch falls through to pc+4; a predicted
  // branch that did not go falls through past its delay slot.
  function automatic br_bus_t resolve_redirect(
    input br_bus_t     pred,
    input logic [31:0] pc,
    input logic        is_branch,
    input logic        taken,
    input logic [31:0] target,
    input logic [31:0] fallthru_off
  );
    br_bus_t r;
    r = '0;
    if (pred.e && !is_branch) begin
      r.e      = 1'b1;
      r.target = pc + 32'd4;
    end else if (pred.e && !taken) begin
      r.e      = 1'b1;
      r.target = pc + fallthru_off;
    end else if (pred.e && (pred.target != target)) begin
      r.e      = 1'b1;
      r.target = target;
    end else if (!pred.e && is_branch && taken) begin
      r.e      = 1'b1;
      r.target = target;
    end
    return r;
  endfunction

endpackage

// File: rtl/branch_resolve_unit_if.sv
// EX-stage branch resolve bus.
//
// Handshake: the redirect on br_bus is a valid/ready pair. br_bus.e is the
// valid and fetch_ready is the ready; a redirect is transferred on a clock
// edge where both are high. Once raised, e stays high and the target stays
// constant until that transfer (or until a flush/reset cancels it).
//
// Signals:
//   ex_valid, ex_pc, ex_is_branch, ex_taken, ex_target : EX instruction and
//                                                        its real outcome
//   bp_to_ex_bus : {pred_e, pred_target} aligned with EX
//   fetch_ready  : PC generator accepts a redirect this cycle
//   br_bus       : {br_e, br_target} redirect + BTB install
//   mispredict   : one-cycle pulse per detected mispredict
//
// Modports: master = pipeline side (EX, predictor, fetch), slave = resolver.
interface branch_resolve_unit_if;
  import branch_resolve_unit_pkg::*;

  logic             ex_valid;
  logic [31:0]      ex_pc;
  logic             ex_is_branch;
  logic             ex_taken;
  logic [31:0]      ex_target;
  logic [BR_WD-1:0] bp_to_ex_bus;
  logic             fetch_ready;
  logic [BR_WD-1:0] br_bus;
  logic             mispredict;

  modport master (
    output ex_valid, ex_pc, ex_is_branch, ex_taken, ex_target,
    output bp_to_ex_bus, fetch_ready,
    input  br_bus, mispredict
  );

  modport slave (
    input  ex_valid, ex_pc, ex_is_branch, ex_taken, ex_target,
    input  bp_to_ex_bus, fetch_ready,
    output br_bus, mispredict
  );

endinterface

// File: rtl/branch_resolve_unit_sat_counter.sv
// Saturating up-counter used for the branch performance counters.
//
// Ports:
//   clk   : clock
//   rst   : asynchronous active-low reset (count -> 0)
//   inc   : add one this cycle unless already all-ones
//   count : current value
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {CNT_W{1'b1}})) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/branch_resolve_unit.sv
// EX-stage branch resolve unit.
//
// Compares the predictor's EX-aligned prediction against the real outcome,
// raises a zero-latency redirect on br_bus when they disagree, holds that
// redirect until fetch takes it, and counts resolved branches/mispredicts.
//
// Ports:
//   clk, rst    : clock, asynchronous active-low reset
//   stall       : pipeline stall vector, bit STALL_EX = EX hold
//   flush       : exception/pipeline flush, cancels any redirect
//   bus         : resolve bus (slave side), see branch_resolve_unit_if
//   dbg_state   : current redirect FSM state
//   branch_cnt  : saturating count of resolved branches
//   mispred_cnt : saturating count of mispredicts
module branch_resolve_unit
  import branch_resolve_unit_pkg::*;
#(
  parameter int          CNT_W        = 32,
  parameter logic [31:0] FALLTHRU_OFF = 32'd8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [STALL_W-1:0]  stall,
  input  logic                flush,
  branch_resolve_unit_if.slave bus,
  output brs_state_e          dbg_state,
  output logic [CNT_W-1:0]    branch_cnt,
  output logic [CNT_W-1:0]    mispred_cnt
);

  brs_state_e  state_q, state_d;
  logic [31:0] pend_target_q, pend_target_d;
  logic        resolved_q, resolved_d;

  br_bus_t pred;
  br_bus_t redir;
  br_bus_t br_out;
  logic    ex_hold;
  logic    eval;
  logic    mis_fire;
  logic    unused_stall;

  assign pred    = bus.bp_to_ex_bus;
  assign ex_hold = (stall[STALL_EX] == STOP);

  // Only the EX hold bit matters here.
  assign unused_stall = ^{stall[STALL_W-1:STALL_EX+1], stall[STALL_EX-1:0]};

  assign redir = resolve_redirect(pred, bus.ex_pc, bus.ex_is_branch,
                                  bus.ex_taken, bus.ex_target, FALLTHRU_OFF);

  // An instruction is looked at once: not while a redirect is still being
  // held, not while flushed, and not again while EX is frozen on it.
  assign eval     = (state_q == IDLE) && bus.ex_valid && !flush && !resolved_q;
  assign mis_fire = eval && redir.e;

  // Redirect output. The live compare result goes out in the same cycle;
  // in HOLD the latched target is replayed. Reset is folded in so that an
  // asynchronous reset drops br_e immediately even with live EX inputs.
  always_comb begin
    br_out = '0;
    if (rst && !flush) begin
      if (state_q == HOLD) begin
        br_out.e      = 1'b1;
        br_out.target = pend_target_q;
      end else if (mis_fire) begin
        br_out = redir;
      end
    end
  end

  assign bus.br_bus     = br_out;
  assign bus.mispredict = rst && mis_fire;

  always_comb begin
    state_d       = state_q;
    pend_target_d = pend_target_q;
    resolved_d    = resolved_q;
    if (flush) begin
      state_d       = IDLE;
      pend_target_d = '0;
      resolved_d    = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (mis_fire && !bus.fetch_ready) begin
            state_d       = HOLD;
            pend_target_d = redir.target;
          end
        end
        HOLD: begin
          if (bus.fetch_ready) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
      // The flag lives exactly as long as EX stays frozen on the instruction
      // that was already evaluated.
      if (!ex_hold) begin
        resolved_d = 1'b0;
      end else if (eval) begin
        resolved_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      pend_target_q <= '0;
      resolved_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      pend_target_q <= pend_target_d;
      resolved_q    <= resolved_d;
    end
  end

  assign dbg_state = state_q;

  sat_counter #(.CNT_W(CNT_W)) u_branch_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (eval && bus.ex_is_branch),
    .count (branch_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_mispred_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (mis_fire),
    .count (mispred_cnt)
  );

endmodule

// File: tb/tb_branch_resolve_unit.sv
module tb_branch_resolve_unit;
  import branch_resolve_unit_pkg::*;

  localparam int CW   = 6;
  localparam int CMAX = (1 << CW) - 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [STALL_W-1:0] stall = '0;
  logic               flush = 1'b0;
  brs_state_e         dbg_state;
  logic [CW-1:0]      branch_cnt;
  logic [CW-1:0]      mispred_cnt;

  branch_resolve_unit_if bus();

  branch_resolve_unit #(.CNT_W(CW), .FALLTHRU_OFF(32'd8)) dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .flush       (flush),
    .bus         (bus),
    .dbg_state   (dbg_state),
    .branch_cnt  (branch_cnt),
    .mispred_cnt (mispred_cnt)
  );

  // ---------------- scoreboard / reference model ----------------
  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q[$];   // redirect targets not yet taken by fetch

  bit          m_hold;     // a redirect is waiting for fetch
  logic [31:0] m_tgt;
  bit          m_res;      // frozen EX instruction already looked at
  int          m_bcnt;
  int          m_mcnt;

  logic [32:0] obs_bus;
  logic        obs_mp;
  logic [CW-1:0] obs_bcnt, obs_mcnt;
  logic        obs_state;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int sat_inc(input int c);
    return (c >= CMAX) ? CMAX : c + 1;
  endfunction

  task automatic model_reset();
    m_hold = 1'b0;
    m_tgt  = '0;
    m_res  = 1'b0;
    m_bcnt = 0;
    m_mcnt = 0;
    exp_q.delete();
  endtask

  // Where execution should really go, from the prediction rules.
  task automatic expected_redirect(input bit pe, input logic [31:0] pt, input logic [31:0] pc,
                                   input bit isb, input bit tk, input logic [31:0] tgt,
                                   output bit mis, output logic [31:0] addr);
    mis  = 1'b0;
    addr = '0;
    if (pe && !isb) begin
      mis = 1'b1; addr = pc + 32'd4;
    end else if (pe && isb && !tk) begin
      mis = 1'b1; addr = pc + 32'd8;
    end else if (pe && isb && tk && (pt != tgt)) begin
      mis = 1'b1; addr = tgt;
    end else if (!pe && isb && tk) begin
      mis = 1'b1; addr = tgt;
    end
  endtask

  // ---------------- driver: one clock cycle ----------------
  task automatic cycle(input bit r, input bit v, input logic [31:0] pc, input bit isb,
                       input bit tk, input logic [31:0] tgt, input bit pe,
                       input logic [31:0] pt, input bit fr, input bit stp, input bit fl);
    bit eval, mis, exp_mp, exp_e;
    logic [31:0] addr, exp_t;
    logic [STALL_W-1:0] s;
    @(negedge clk);
    rst              = r;
    bus.ex_valid     = v;
    bus.ex_pc        = pc;
    bus.ex_is_branch = isb;
    bus.ex_taken     = tk;
    bus.ex_target    = tgt;
    bus.bp_to_ex_bus = {pe, pt};
    bus.fetch_ready  = fr;
    s                = STALL_W'($urandom);
    s[STALL_EX]      = stp;
    stall            = s;
    flush            = fl;
    #2;
    if (!r) model_reset();
    expected_redirect(pe, pt, pc, isb, tk, tgt, mis, addr);
    eval   = r && !m_hold && v && !fl && !m_res;
    exp_mp = eval && mis;
    exp_e  = r && !fl && (m_hold || exp_mp);
    exp_t  = !exp_e ? 32'h0 : (m_hold ? m_tgt : addr);

    obs_bus   = bus.br_bus;
    obs_mp    = bus.mispredict;
    obs_bcnt  = branch_cnt;
    obs_mcnt  = mispred_cnt;
    obs_state = dbg_state;

    check_val("br_bus", 64'(obs_bus), 64'({exp_e, exp_t}));
    check_val("mispredict", 64'(obs_mp), 64'(exp_mp));
    check_val("state", 64'(obs_state), 64'(m_hold));
    check_val("branch_cnt", 64'(obs_bcnt), 64'(m_bcnt));
    check_val("mispred_cnt", 64'(obs_mcnt), 64'(m_mcnt));

    // Every accepted redirect must be one the model is still owed.
    if (exp_mp) exp_q.push_back(addr);
    if (obs_bus[32] && fr) begin
      if (exp_q.size() == 0) check_val("deliver_unexpected", 64'(obs_bus), 64'h0);
      else check_val("deliver", 64'(obs_bus[31:0]), 64'(exp_q.pop_front()));
    end

    if (r) begin
      if (fl) begin
        if (m_hold && exp_q.size() > 0) void'(exp_q.pop_front());
        m_hold = 1'b0;
        m_tgt  = '0;
        m_res  = 1'b0;
      end else begin
        if (m_hold) begin
          if (fr) m_hold = 1'b0;
        end else if (exp_mp && !fr) begin
          m_hold = 1'b1;
          m_tgt  = addr;
        end
        if (!stp) m_res = 1'b0;
        else if (eval) m_res = 1'b1;
        if (eval && isb) m_bcnt = sat_inc(m_bcnt);
        if (exp_mp) m_mcnt = sat_inc(m_mcnt);
      end
    end
  endtask

  task automatic idle(input bit fr);
    cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, fr, 1'b0, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  int n_high, n_mp;

  initial begin
    model_reset();
    bus.ex_valid = 1'b0; bus.ex_pc = '0; bus.ex_is_branch = 1'b0; bus.ex_taken = 1'b0;
    bus.ex_target = '0; bus.bp_to_ex_bus = '0; bus.fetch_ready = 1'b1;

    // Reset held with a live mispredicting instruction: nothing comes out.
    repeat (2) cycle(1'b0, 1'b1, 32'h10, 1'b1, 1'b1, 32'h80, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    check_val("rst_br_bus", 64'(obs_bus), 64'h0);
    check_val("rst_cnt", 64'({obs_bcnt, obs_mcnt}), 64'h0);

    // Unpredicted taken branch, fetch ready.
    cycle(1'b1, 1'b1, 32'h80000000, 1'b1, 1'b1, 32'h80000100, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    check_val("t1_bus", 64'(obs_bus), 64'({1'b1, 32'h80000100}));
    check_val("t1_mp", 64'(obs_mp), 64'h1);
    idle(1'b1);
    check_val("t1_cnt", 64'({obs_bcnt, obs_mcnt}), 64'({6'd1, 6'd1}));

    // Predicted taken but fell through; predicted taken on a non-branch.
    cycle(1'b1, 1'b1, 32'h100, 1'b1, 1'b0, 32'h300, 1'b1, 32'h200, 1'b1, 1'b0, 1'b0);
    check_val("t2_fallthru", 64'(obs_bus), 64'({1'b1, 32'h108}));
    cycle(1'b1, 1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 1'b1, 32'h200, 1'b1, 1'b0, 1'b0);
    check_val("t2_nonbranch", 64'(obs_bus), 64'({1'b1, 32'h104}));

    // Correct prediction.
    cycle(1'b1, 1'b1, 32'h400, 1'b1, 1'b1, 32'h500, 1'b1, 32'h500, 1'b1, 1'b0, 1'b0);
    check_val("t3_br_e", 64'(obs_bus[32]), 64'h0);
    idle(1'b1);
    check_val("t3_cnt", 64'({obs_bcnt, obs_mcnt}), 64'({6'd3, 6'd3}));

    // Redirect held for three not-ready cycles; EX target wiggles meanwhile.
    n_high = 0; n_mp = 0;
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 1'b1, 32'h1000, 1'b1, 1'b1, 32'h2000 + 32'(i * 16), 1'b0, 32'h0,
            (i == 3), 1'b0, 1'b0);
      n_high += int'(obs_bus[32]);
      n_mp   += int'(obs_mp);
      check_val("t4_tgt", 64'(obs_bus[31:0]), 64'h2000);
    end
    idle(1'b1);
    check_val("t4_high_cycles", 64'(n_high), 64'd4);
    check_val("t4_pulses", 64'(n_mp), 64'd1);
    check_val("t4_after", 64'({obs_state, obs_bus[32]}), 64'h0);

    // Mispredict while EX is frozen for five cycles.
    n_mp = 0;
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 1'b1, 32'h5000, 1'b1, 1'b1, 32'h6000, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
      n_mp += int'(obs_mp);
    end
    cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    check_val("t5_pulses", 64'(n_mp), 64'd1);
    check_val("t5_cnt", 64'({obs_bcnt, obs_mcnt}), 64'({6'd5, 6'd5}));

    // Flush on top of a mispredict.
    cycle(1'b1, 1'b1, 32'h7000, 1'b1, 1'b1, 32'h7100, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
    check_val("t6_bus", 64'({obs_mp, obs_bus}), 64'h0);
    idle(1'b1);
    check_val("t6_cnt", 64'({obs_bcnt, obs_mcnt}), 64'({6'd5, 6'd5}));

    // Flush during HOLD.
    cycle(1'b1, 1'b1, 32'h8000, 1'b1, 1'b1, 32'h8100, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    check_val("t7_flush_bus", 64'(obs_bus), 64'h0);
    idle(1'b0);
    check_val("t7_after", 64'({obs_state, obs_bus[32]}), 64'h0);
    check_val("t7_cnt", 64'({obs_bcnt, obs_mcnt}), 64'({6'd6, 6'd6}));

    // Asynchronous reset in the middle of HOLD.
    cycle(1'b1, 1'b1, 32'h9000, 1'b1, 1'b1, 32'h9100, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 32'h9000, 1'b1, 1'b1, 32'h9100, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    check_val("t8_rst_bus", 64'(obs_bus), 64'h0);
    check_val("t8_rst_state", 64'(obs_state), 64'h0);
    idle(1'b1);

    // Saturation: more mispredicting branches than the counters can hold.
    for (int i = 0; i < CMAX + 7; i++) begin
      cycle(1'b1, 1'b1, 32'(i * 4), 1'b1, 1'b1, 32'h4000, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    end
    idle(1'b1);
    check_val("sat_cnt", 64'({obs_bcnt, obs_mcnt}), 64'({6'h3f, 6'h3f}));

    // Randomized traffic against the model.
    cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 800; i++) begin
      logic [31:0] pc, tgt, pt;
      bit isb, pe;
      pc  = ($urandom_range(0, 19) == 0) ? 32'hFFFFFFFC : ($urandom & 32'hFFFFFFFC);
      tgt = $urandom & 32'hFFFFFFFC;
      pt  = ($urandom_range(0, 1) == 0) ? tgt : ($urandom & 32'hFFFFFFFC);
      isb = ($urandom_range(0, 3) != 0);
      pe  = ($urandom_range(0, 1) == 1);
      cycle(1'b1, ($urandom_range(0, 99) < 85), pc, isb, ($urandom_range(0, 1) == 1), tgt,
            pe, pt, ($urandom_range(0, 99) < 70), ($urandom_range(0, 99) < 30),
            ($urandom_range(0, 99) < 5));
    end

    // Let any held redirect drain.
    repeat (3) idle(1'b1);
    check_val("sb_leftover", 64'(exp_q.size()), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- EX-stage consumer of the predictor's EX-aligned prediction bus (bp_to_ex_bus).
- Compares the prediction against the actual branch outcome computed in EX, and drives br_bus (redirect / BTB-install) back to the PC generator and branch predictor.
- Resolves each EX instruction exactly once, even when EX is stalled.
- Holds a redirect until fetch accepts it and keeps saturating branch/mispredict counters.

Parameters:
- CNT_W, 32, width of each performance counter.
- FALLTHRU_OFF, 8, fall-through offset for a not-taken branch (branch plus delay slot).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- stall  in  `StallBus  pipeline stall vector; bit 3 = EX hold.
- flush  in  1  exception/pipeline flush.
- ex_valid  in  1  EX holds a live instruction.
- ex_pc  in  32  PC of the EX instruction.
- ex_is_branch  in  1  EX instruction is a branch/jump.
- ex_taken  in  1  actual direction from EX compare.
- ex_target  in  32  actual taken target.
- bp_to_ex_bus  in  `BR_WD  {pred_e, pred_target} aligned with EX.
- fetch_ready  in  1  PC generator accepts a redirect this cycle.
- br_bus  out  `BR_WD  {br_e, br_target}: redirect plus BTB install.
- mispredict  out  1  single-cycle pulse per detected mispredict.
- branch_cnt  out  CNT_W  resolved branches.
- mispred_cnt  out  CNT_W  mispredicts.

Behaviour:
- Reset (rst low, asynchronous): state = IDLE; br_e = 0; br_target = 0; mispredict = 0; both counters = 0; pending target reg = 0; resolved flag = 0.
- Evaluation happens when state == IDLE, ex_valid = 1, flush = 0 and the resolved flag is clear. Mispredict cases, evaluated combinationally:
  - pred_e = 1, ex_is_branch = 0: redirect to ex_pc+4.
  - pred_e = 1, branch, not taken: redirect to ex_pc+FALLTHRU_OFF.
  - pred_e = 1, taken, pred_target != ex_target: redirect to ex_target.
  - pred_e = 0, branch, taken: redirect to ex_target.
  - All other cases are correct; no redirect.
- Address arithmetic is 32-bit modulo; wrap at 0xFFFFFFFC is not special-cased.
- On a mispredict:
  - br_e = 1 and br_target = the redirect address in the same cycle (zero-latency, combinational).
  - mispredict pulses for 1 cycle.
- If fetch_ready = 0 when the redirect is raised:
  - The redirect target is latched and the state moves to HOLD.
  - In HOLD, br_e stays 1 with the latched target until fetch_ready = 1, then the state returns to IDLE. That cycle is the last cycle br_e is high.
  - New evaluations are suppressed while in HOLD.
- Resolved flag:
  - Set on any evaluation (mispredict or not) while stall[3] == `Stop.
  - Cleared when stall[3] == `NoStop.
  - This prevents a stalled EX instruction from double-counting or re-redirecting.
- Counters:
  - branch_cnt increments on each evaluated instruction with ex_is_branch = 1.
  - mispred_cnt increments on each mispredict.
  - Both saturate at all-ones.
- flush:
  - Forces br_e = 0, returns to IDLE, clears the pending target and the resolved flag.
  - Flush wins over a simultaneous mispredict; the counters do not increment that cycle.
- Reset asserted mid-HOLD drops br_e asynchronously.

Decomposition:
- Shared defines header holds `BR_WD, `StallBus, `Stop/`NoStop and the state encodings IDLE = 1'b0, HOLD = 1'b1.
- One natural sub-module: sat_counter (parameter CNT_W; inc, count), instantiated twice.

Test Plan:
- Reset released, ex_pc = 0x80000000, pred_e = 0, branch taken to 0x80000100, fetch_ready = 1 -> same cycle br_bus = {1, 0x80000100}; mispredict pulse; branch_cnt = 1, mispred_cnt = 1.
- pred_e = 1, pred_target = 0x200, branch not taken at ex_pc = 0x100 -> br_target = 0x108. pred_e = 1 on a non-branch at 0x100 -> br_target = 0x104.
- Correct prediction (pred_e = 1, target match, taken) -> br_e = 0; branch_cnt +1, mispred_cnt unchanged.
- Mispredict with fetch_ready = 0 for 3 cycles -> br_e high 4 cycles with a constant target; mispredict pulses once; changing ex_target during HOLD has no effect.
- Mispredict while stall[3] = Stop for 5 cycles -> exactly one mispredict pulse; counters +1 only.
- flush concurrent with a mispredict, and flush during HOLD -> br_e = 0 next cycle, state IDLE; counters preloaded near all-ones saturate rather than wrap.
